// File: rtl/nano_uart_tx_if.sv
// CPU data-bus view of the UART transmitter: select, word offset, store data,
// write strobe and combinational read data.
interface nano_uart_tx_if;
    logic        sel;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic        mem_wr;
    logic [31:0] rd_data;

    // CPU side drives the request and samples read data.
    modport master (
        output sel,
        output addr,
        output wr_data,
        output mem_wr,
        input  rd_data
    );

    // Peripheral side decodes the request and returns read data.
    modport slave (
        input  sel,
        input  addr,
        input  wr_data,
        input  mem_wr,
        output rd_data
    );
endinterface

// File: rtl/nano_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the nanoCPU data bus.
// Register map (word offsets): 0 TXDATA (push), 1 STATUS, 2 BAUD, 3 unused.
// Bytes go through a small FIFO; the serialiser pops directly from it so
// queued frames are sent back to back with no idle clocks in between.
module nano_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clock,
    input  logic          reset,
    nano_uart_tx_if.slave bus,
    output logic          txd,
    output logic          irq
);

    localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0]     BAUD_RST  = (CLKS_PER_BIT < 1) ? 16'd1 : 16'(CLKS_PER_BIT);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [23:0] rsvd;
        logic [3:0]  count;
        logic        ovf;
        logic        empty;
        logic        full;
        logic        busy;
    } status_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    logic            ovf;
    logic [15:0]     baud_reg;
    logic [15:0]     active_div;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic            wr_en;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            busy;
    logic            bit_done;
    logic            ovf_set;
    logic            ovf_clr;
    logic [31:0]     rd_word;
    status_t         status;
    logic            unused_bits;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign wr_en    = bus.sel & bus.mem_wr;
    assign push_req = wr_en && (bus.addr == 2'd0);
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // Full is judged on the pre-edge count, even if a pop frees a slot this edge.
    assign push     = push_req & ~full;
    assign ovf_set  = push_req & full;
    assign ovf_clr  = wr_en && (bus.addr == 2'd1) && bus.wr_data[3];

    // Upper store-data bits have no register behind them.
    assign unused_bits = ^bus.wr_data[31:16];

    // Current bit has been held for the full divider period.
    assign bit_done = (baud_cnt == active_div - 16'd1);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: a non-empty FIFO always starts (or chains) a frame.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!empty) state_nxt = START;
            START: if (bit_done) state_nxt = DATA;
            DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_done) state_nxt = empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: line level, busy, and the pop that loads a new frame.
    always_comb begin
        txd  = 1'b1;
        busy = 1'b1;
        pop  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                pop  = !empty;
            end
            START: txd = 1'b0;
            DATA:  txd = shreg[0];
            STOP:  pop = bit_done && !empty;
            default: busy = 1'b0;
        endcase
    end

    assign irq = empty & ~busy;

    // ------------------------------------------------------------------
    // Serialiser datapath
    // ------------------------------------------------------------------
    // Bit timer, bit index and shifter; divider is latched per frame on pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            active_div <= BAUD_RST;
        end else if (pop) begin
            shreg      <= fifo_mem[rd_ptr];
            active_div <= baud_reg;
            baud_cnt   <= '0;
            bit_idx    <= '0;
        end else if (state != IDLE) begin
            if (bit_done) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= bus.wr_data[7:0];
    end

    // Pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // Sticky overflow; a set wins over a clear on the same edge.
    always_ff @(posedge clock) begin
        if (reset) ovf <= 1'b0;
        else       ovf <= ovf_set | (ovf & ~ovf_clr);
    end

    // Baud divider; zero would stall the bit timer, so it is stored as one.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_reg <= BAUD_RST;
        end else if (wr_en && bus.addr == 2'd2) begin
            baud_reg <= (bus.wr_data[15:0] == 16'd0) ? 16'd1 : bus.wr_data[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, pre-edge state)
    // ------------------------------------------------------------------
    // Status word assembly and offset select; nothing is driven without sel.
    always_comb begin
        status       = '0;
        status.busy  = busy;
        status.full  = full;
        status.empty = empty;
        status.ovf   = ovf;
        status.count = 4'(count);
        rd_word      = '0;
        if (bus.sel) begin
            unique case (bus.addr)
                2'd1:    rd_word = status;
                2'd2:    rd_word = {16'h0000, baud_reg};
                default: rd_word = '0;
            endcase
        end
    end

    assign bus.rd_data = rd_word;

endmodule

// File: tb/tb_nano_uart_tx.sv
// Self-checking bench for nano_uart_tx: directed scenarios plus randomized
// bursts, with txd captured every cycle and compared to ideal 8N1 frames.
module tb_nano_uart_tx;

    logic clock = 1'b0;
    logic reset;
    logic txd;
    logic irq;

    nano_uart_tx_if bus_if ();

    int checks = 0;
    int errors = 0;

    // Captured line samples (one per clock) and the expected frame list.
    logic       cap_q[$];
    bit         cap_en = 1'b0;
    logic [7:0] exp_byte[$];
    int         exp_baud[$];
    bit         exp_contig[$];

    nano_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
        .txd   (txd),
        .irq   (irq)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (cap_en) cap_q.push_back(txd);

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Ideal 8N1 frame: bit 0 start (low), 1..8 data LSB first, 9 stop (high).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic s, input logic [1:0] a, input logic [31:0] d);
        bus_if.sel     = s;
        bus_if.mem_wr  = 1'b1;
        bus_if.addr    = a;
        bus_if.wr_data = d;
        tick();
        bus_if.sel     = 1'b0;
        bus_if.mem_wr  = 1'b0;
        bus_if.wr_data = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        bus_if.sel    = 1'b1;
        bus_if.mem_wr = 1'b0;
        bus_if.addr   = a;
        #1;
        v = bus_if.rd_data;
        bus_if.sel    = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (irq !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("idle_wait", {31'd0, irq}, 32'd1);
    endtask

    task automatic expect_frame(input logic [7:0] b, input int baud, input bit contig);
        exp_byte.push_back(b);
        exp_baud.push_back(baud);
        exp_contig.push_back(contig);
    endtask

    task automatic start_cap();
        cap_q.delete();
        exp_byte.delete();
        exp_baud.delete();
        exp_contig.delete();
        cap_en = 1'b1;
    endtask

    // Walk the capture: each frame bit must last exactly its baud in clocks;
    // contiguous frames must start on the very next sample, and the line
    // must stay high after the last frame.
    task automatic check_stream(input string tag);
        int pos = 0;
        int good;
        int rem;
        foreach (exp_byte[i]) begin
            if (!exp_contig[i])
                while (pos < cap_q.size() && cap_q[pos] === 1'b1) pos++;
            for (int k = 0; k < 10; k++) begin
                good = 0;
                for (int j = 0; j < exp_baud[i]; j++) begin
                    if (pos < cap_q.size() && cap_q[pos] === frame_bit(exp_byte[i], k)) good++;
                    pos++;
                end
                chk($sformatf("%s f%0d b%0d", tag, i, k), good, exp_baud[i]);
            end
        end
        rem  = (pos < cap_q.size()) ? cap_q.size() - pos : 0;
        good = 0;
        for (int p = pos; p < cap_q.size(); p++) if (cap_q[p] === 1'b1) good++;
        chk($sformatf("%s tail", tag), good, rem);
    endtask

    task automatic end_cap(input string tag);
        repeat (3) tick();
        cap_en = 1'b0;
        check_stream(tag);
    endtask

    initial begin
        logic [31:0] v;

        bus_if.sel     = 1'b0;
        bus_if.mem_wr  = 1'b0;
        bus_if.addr    = '0;
        bus_if.wr_data = '0;
        reset          = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state.
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd1);
        rd(2'd1, v); chk("rst_status", v, 32'h04);
        rd(2'd2, v); chk("rst_baud", v, 32'd16);
        tick();
        rd(2'd0, v); chk("rd_txdata_zero", v, 32'h0);
        rd(2'd3, v); chk("rd_off3_zero", v, 32'h0);
        bus_if.addr = 2'd2;
        #1;
        chk("rd_unselected", bus_if.rd_data, 32'h0);

        // Deselected writes and offset-3 writes change nothing.
        wr(1'b0, 2'd0, 32'h55);
        wr(1'b0, 2'd2, 32'h7);
        wr(1'b1, 2'd3, 32'hFFFF_FFFF);
        rd(2'd1, v); chk("nosel_status", v, 32'h04);
        rd(2'd2, v); chk("nosel_baud", v, 32'd16);
        chk("nosel_txd", {31'd0, txd}, 32'd1);

        // Single byte 0xA5 at 4 clocks/bit with exact latency and irq timing.
        wr(1'b1, 2'd2, 32'd4);
        start_cap();
        wr(1'b1, 2'd0, 32'hA5);
        rd(2'd1, v); chk("a5_status_pushed", v, 32'h10);
        chk("a5_txd_before_pop", {31'd0, txd}, 32'd1);
        tick();
        chk("a5_txd_start", {31'd0, txd}, 32'd0);
        chk("a5_irq_busy", {31'd0, irq}, 32'd0);
        rd(2'd1, v); chk("a5_status_popped", v, 32'h05);
        for (int i = 0; i < 39; i++) begin
            tick();
            chk($sformatf("a5_irq_low c%0d", i), {31'd0, irq}, 32'd0);
        end
        tick();
        chk("a5_irq_back", {31'd0, irq}, 32'd1);
        rd(2'd1, v); chk("a5_status_idle", v, 32'h04);
        expect_frame(8'hA5, 4, 1'b0);
        end_cap("a5");

        // Overflow at 100 clocks/bit: five accepted, sixth dropped.
        wr(1'b1, 2'd2, 32'd100);
        start_cap();
        for (int i = 0; i < 6; i++) begin
            wr(1'b1, 2'd0, 32'h11 + i);
            if (i < 5) expect_frame(8'(8'h11 + i), 100, i > 0);
        end
        rd(2'd1, v); chk("ovf_status", v, 32'h4B);
        wr(1'b1, 2'd1, 32'h8);
        rd(2'd1, v); chk("ovf_cleared", v, 32'h43);
        wait_idle(8000);
        end_cap("ovf");

        // Back-to-back 0x00 / 0xFF at 2 clocks/bit.
        wr(1'b1, 2'd2, 32'd2);
        start_cap();
        wr(1'b1, 2'd0, 32'h00);
        wr(1'b1, 2'd0, 32'hFF);
        expect_frame(8'h00, 2, 1'b0);
        expect_frame(8'hFF, 2, 1'b1);
        wait_idle(200);
        end_cap("b2b");

        // BAUD rewritten to 0 during DATA: frame in flight keeps 4, next uses 1.
        wr(1'b1, 2'd2, 32'd4);
        start_cap();
        wr(1'b1, 2'd0, 32'h3C);
        repeat (6) tick();
        wr(1'b1, 2'd2, 32'd0);
        rd(2'd2, v); chk("baud_zero_reads_one", v, 32'd1);
        wr(1'b1, 2'd0, 32'hC3);
        expect_frame(8'h3C, 4, 1'b0);
        expect_frame(8'hC3, 1, 1'b1);
        wait_idle(200);
        end_cap("baudchg");

        // Randomized bursts of consecutive writes; a frame lasts at least
        // 10 clocks, so only the first byte leaves the FIFO during a burst
        // and a sixth consecutive write is the first to be dropped.
        for (int r = 0; r < 8; r++) begin
            int          bd;
            int          n;
            logic [31:0] d;
            bd = $urandom_range(1, 6);
            n  = $urandom_range(1, 6);
            wr(1'b1, 2'd2, bd);
            start_cap();
            for (int i = 0; i < n; i++) begin
                d = $urandom();
                wr(1'b1, 2'd0, d);
                if (i < 5) expect_frame(d[7:0], bd, i > 0);
            end
            rd(2'd1, v); chk($sformatf("rnd%0d_ovf", r), {31'd0, v[3]}, {31'd0, n > 5});
            wr(1'b1, 2'd1, 32'h8);
            rd(2'd1, v); chk($sformatf("rnd%0d_ovf_clr", r), {31'd0, v[3]}, 32'd0);
            wait_idle(2000);
            end_cap($sformatf("rnd%0d", r));
        end

        // Reset during data bit 3 with two bytes still queued.
        wr(1'b1, 2'd2, 32'd4);
        wr(1'b1, 2'd0, 32'h52);
        wr(1'b1, 2'd0, 32'h66);
        wr(1'b1, 2'd0, 32'h77);
        repeat (16) tick();
        chk("mid_bit3_low", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        tick();
        chk("mid_rst_txd", {31'd0, txd}, 32'd1);
        chk("mid_rst_irq", {31'd0, irq}, 32'd1);
        rd(2'd1, v); chk("mid_rst_status", v, 32'h04);
        reset = 1'b0;
        rd(2'd2, v); chk("mid_rst_baud", v, 32'd16);
        start_cap();
        repeat (100) tick();
        end_cap("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nano_uart_tx.md
# nano_uart_tx

Memory-mapped UART transmitter that acts as a responder on the nanoCPU data bus, alongside data memory. The CPU drives address, write data and the write strobe. The block decodes its four word registers, buffers bytes in a small FIFO and serialises them on `txd` as 8N1 frames. Reads are combinational, like data memory, so single-cycle loads complete in the same cycle.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: reset value of the baud divider, in clocks per bit.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of 2, max 8.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  chip select, decoded from the upper data-address bits by the system.
- `addr`  in  2  word offset, taken from data address bits [3:2].
- `wr_data`  in  32  CPU store data.
- `mem_wr`  in  1  write strobe; a write occurs when `sel & mem_wr` is high at a rising edge.
- `rd_data`  out  32  combinational read data; 0 when `sel` is low.
- `txd`  out  1  serial output; idles high.
- `irq`  out  1  high when the FIFO is empty and the shifter is idle.

## Operation
- Offset 0, TXDATA.
  - Write: pushes `wr_data[7:0]` if the FIFO is not full, judged on the pre-edge count.
  - Write while full: byte dropped, `ovf` set.
  - Read: returns 0.
- Offset 1, STATUS (read).
  - [0] busy = FSM not in IDLE.
  - [1] full; [2] empty; [3] ovf (sticky); [7:4] count.
  - Other bits 0.
- Offset 1, STATUS (write): `wr_data[3]=1` clears `ovf`. A clear and a set in the same edge leave `ovf=1`.
- Offset 2, BAUD.
  - R/W, 16 bits in [15:0].
  - Written value 0 stored as 1.
  - The value is sampled into the active divider only when a frame starts (on pop); frames in flight are unaffected.
- Offset 3: reads 0; writes ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START: the FIFO is non-empty. Pop the byte into the shifter; `txd`=0.
  - START→DATA after `baud` clocks. Bit index 0, LSB first.
  - DATA: after each `baud` clocks shift; after bit 7 go to STOP with `txd`=1.
  - STOP→START after `baud` clocks if the FIFO is non-empty (pop, no idle gap); otherwise STOP→IDLE.
- FIFO count:
  - Push and pop in the same edge: count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset state:
  - `txd`=1, `irq`=1, FSM IDLE.
  - FIFO empty with pointers 0; `ovf`=0; BAUD=`CLKS_PER_BIT`; bit counter 0.
- Reset mid-frame: at the reset edge `txd`=1, the FIFO is flushed and the frame is abandoned.
- Push at edge N:
  - `empty`=0 visible after N.
  - Pop and `txd` fall at edge N+1; busy=1 and `irq`=0 after N+1.
- Each bit, including start and stop, is held for exactly `baud` clocks.
  - Frame length 10×`baud` clocks.
  - Back-to-back frames have no idle clocks between stop and the next start.
- `rd_data` is combinational from `sel`, `addr` and current state; it reflects the pre-edge state during a write cycle.
- Writes with `sel`=0 have no effect.

## Test plan
- Reset then idle: hold `reset` for 2 clocks → `txd`=1, `irq`=1, STATUS read = 0x04, BAUD read = 16.
- Single byte, BAUD=4: write 0xA5 to offset 0 at edge N.
  - From N+1: `txd` = 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks.
  - `irq` returns to 1 at N+41.
- Overflow, BAUD=100: five writes 0x11..0x15 in consecutive cycles.
  - First pops after one cycle, so the FIFO holds 4 and none drop.
  - A sixth write, 0x16, → dropped; STATUS = 0x4B.
  - Write STATUS `wr_data`=0x8 → ovf cleared.
- Back-to-back, BAUD=2: write 0x00 then 0xFF → 40 continuous clocks of frame data with no high gap between the first stop bit and the second start bit.
- BAUD change mid-frame: start a frame at BAUD=4, then write BAUD=0 during DATA.
  - Current frame stays at 4 clocks/bit; BAUD reads 1.
  - The next frame runs at 1 clock/bit.
- Reset mid-frame during bit 3 with 2 bytes queued → `txd`=1 and STATUS=0x04 after the reset edge; no further frame is emitted.
